// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multicycle CPU control sequencer.
package cpu_seq_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned ALU_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
    localparam logic [OPC_W-1:0] OP_SLT  = 4'h4;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h5;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;

    localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

    // Datapath controls implied by one opcode.
    typedef struct packed {
        logic [ALU_W-1:0] alu_control;
        logic             alu_src;
        logic             reg_dst;
        logic             writes;
        logic             illegal;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Opcode decoder: maps a 4-bit opcode to ALU op, operand/destination
// selects, register-write enable and an illegal-opcode flag.
//   opcode : instruction bits [15:12]
//   dec_c  : combinational control bundle
module instr_decoder
    import cpu_seq_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec_c
);

    always_comb begin
        // Unknown opcodes: harmless ADD setting, no write, flagged illegal.
        dec_c = '{alu_control: ALU_ADD, alu_src: 1'b0, reg_dst: 1'b0,
                  writes: 1'b0, illegal: 1'b1};
        case (opcode)
            OP_ADD:  dec_c = '{ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0};
            OP_SUB:  dec_c = '{ALU_SUB, 1'b0, 1'b1, 1'b1, 1'b0};
            OP_AND:  dec_c = '{ALU_AND, 1'b0, 1'b1, 1'b1, 1'b0};
            OP_OR:   dec_c = '{ALU_OR,  1'b0, 1'b1, 1'b1, 1'b0};
            OP_SLT:  dec_c = '{ALU_SLT, 1'b0, 1'b1, 1'b1, 1'b0};
            OP_ADDI: dec_c = '{ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/WB with an
// instruction-memory handshake, run/step/halt control and a retire counter.
//   clock, reset_n     : rising-edge clock, synchronous active-low reset
//   run, step          : continuous run level / single-instruction pulse
//   imem_req, imem_ack : fetch request and memory data-valid
//   instr              : instruction word
//   ir_load            : IR load, qualified by imem_ack in the same cycle
//   pc_write, reg_write, illegal : single-cycle WB strobes
//   reg_dst, alu_src, alu_control : datapath selects, valid in EXEC and WB
//   busy, halted       : status
//   retired            : completed-instruction count (wraps)
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                run,
    input  logic                step,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  instr,
    output logic                ir_load,
    output logic                pc_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                alu_src,
    output logic [ALU_W-1:0]    alu_control,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    state_t                state_q, state_d;
    logic                  single_mode_q, single_mode_d;
    logic [OPC_W-1:0]      opcode_q, opcode_d;
    logic [OPC_W-1:0]      dec_opcode;
    dec_t                  dec_c;

    logic                  imem_req_d, pc_write_d, reg_write_d, illegal_d;
    logic                  reg_dst_d, alu_src_d, busy_d, halted_d;
    logic [ALU_W-1:0]      alu_control_d;
    logic [RETIRE_W-1:0]   retired_d;

    // Decode the live word while in DECODE so the EXEC-entry registers
    // already see the new opcode; afterwards use the latched copy.
    assign dec_opcode = (state_q == DECODE) ? instr[INSTR_W-1 -: OPC_W] : opcode_q;

    instr_decoder u_dec (
        .opcode (dec_opcode),
        .dec_c  (dec_c)
    );

    // IR load must line up with the ack cycle, so it is qualified by the
    // live ack; reset suppresses it so an ack during reset is dropped.
    assign ir_load = reset_n && (state_q == FETCH) && imem_ack;

    // Next state and next values of every registered output.
    always_comb begin
        state_d       = state_q;
        single_mode_d = single_mode_q;
        opcode_d      = opcode_q;
        imem_req_d    = 1'b0;
        pc_write_d    = 1'b0;
        reg_write_d   = 1'b0;
        illegal_d     = 1'b0;
        reg_dst_d     = 1'b0;
        alu_src_d     = 1'b0;
        alu_control_d = '0;
        busy_d        = 1'b0;
        halted_d      = 1'b0;
        retired_d     = retired;

        case (state_q)
            IDLE: begin
                if (run || step) begin
                    state_d       = FETCH;
                    single_mode_d = ~run;
                end
            end
            FETCH:   if (imem_ack) state_d = DECODE;
            DECODE: begin
                opcode_d = instr[INSTR_W-1 -: OPC_W];
                state_d  = (instr == HALT_WORD) ? HALT : EXEC;
            end
            EXEC:    state_d = WB;
            WB:      state_d = (single_mode_q || !run) ? IDLE : FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        imem_req_d = (state_d == FETCH);
        busy_d     = (state_d != IDLE) && (state_d != HALT);
        halted_d   = (state_d == HALT);

        if (state_d == EXEC || state_d == WB) begin
            alu_control_d = dec_c.alu_control;
            alu_src_d     = dec_c.alu_src;
            reg_dst_d     = dec_c.reg_dst;
        end

        if (state_d == WB) begin
            pc_write_d  = 1'b1;
            reg_write_d = dec_c.writes;
            illegal_d   = dec_c.illegal;
            retired_d   = retired + RETIRE_W'(1);
        end
    end

    // State, control flags and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            single_mode_q <= 1'b0;
            opcode_q      <= '0;
            imem_req      <= 1'b0;
            pc_write      <= 1'b0;
            reg_write     <= 1'b0;
            illegal       <= 1'b0;
            reg_dst       <= 1'b0;
            alu_src       <= 1'b0;
            alu_control   <= '0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            retired       <= '0;
        end else begin
            state_q       <= state_d;
            single_mode_q <= single_mode_d;
            opcode_q      <= opcode_d;
            imem_req      <= imem_req_d;
            pc_write      <= pc_write_d;
            reg_write     <= reg_write_d;
            illegal       <= illegal_d;
            reg_dst       <= reg_dst_d;
            alu_src       <= alu_src_d;
            alu_control   <= alu_control_d;
            busy          <= busy_d;
            halted        <= halted_d;
            retired       <= retired_d;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer. Expected writeback records are queued
// as each instruction is launched; a monitor pops one on every pc_write.
// The retire counter is narrowed so its wrap can be reached quickly.
module tb_cpu_sequencer;

    localparam int unsigned RW = 8;

    logic          clock;
    logic          reset_n, run, step, imem_ack;
    logic [15:0]   instr;
    logic          imem_req, ir_load, pc_write, reg_write, reg_dst, alu_src;
    logic [3:0]    alu_control;
    logic          busy, halted, illegal;
    logic [RW-1:0] retired;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 0;
    int wcnt     = 0;

    typedef struct {
        logic [3:0]    alu;
        logic          src;
        logic          dst;
        logic          rw;
        logic          ill;
        logic [RW-1:0] ret;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    cpu_sequencer #(.RETIRE_W(RW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .step        (step),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .alu_control (alu_control),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] alu, input logic src, input logic dst,
                            input logic rw, input logic ill, input logic [RW-1:0] ret);
        exp_t e;
        e.alu = alu; e.src = src; e.dst = dst; e.rw = rw; e.ill = ill; e.ret = ret;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clock);
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: busy still high after %0d cycles, required 0", name, max_cyc);
        end
    endtask

    // Instruction memory: ack after mem_lat wait states, drop once req falls.
    initial begin
        imem_ack = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (imem_req && !imem_ack) begin
                if (wcnt >= mem_lat) imem_ack = 1'b1;
                else                 wcnt++;
            end else begin
                imem_ack = 1'b0;
                wcnt     = 0;
            end
        end
    end

    // Writeback monitor.
    always @(negedge clock) begin
        if (pc_write) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wb: pc_write with nothing expected, got retired=%0h, required no pc_write", retired);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_alu_control", 32'(alu_control), 32'(mon_e.alu));
                chk("wb_alu_src",     32'(alu_src),     32'(mon_e.src));
                chk("wb_reg_dst",     32'(reg_dst),     32'(mon_e.dst));
                chk("wb_reg_write",   32'(reg_write),   32'(mon_e.rw));
                chk("wb_illegal",     32'(illegal),     32'(mon_e.ill));
                chk("wb_retired",     32'(retired),     32'(mon_e.ret));
            end
        end
        if (reg_write || illegal) chk("strobe_only_in_wb", 32'(pc_write), 32'd1);
        if (halted)
            chk("halt_quiet", 32'({pc_write, reg_write, illegal, imem_req, ir_load, busy}), 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    int req_cnt, ack_c, pw_c, pw1, pw2;

    initial begin
        reset_n = 1'b0; run = 1'b1; step = 1'b0; instr = 16'h0180; mem_lat = 0;

        // Reset held three cycles with run high.
        repeat (3) @(negedge clock);
        chk("rst_imem_req",    32'(imem_req),    32'd0);
        chk("rst_ir_load",     32'(ir_load),     32'd0);
        chk("rst_pc_write",    32'(pc_write),    32'd0);
        chk("rst_reg_write",   32'(reg_write),   32'd0);
        chk("rst_alu_control", 32'(alu_control), 32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_halted",      32'(halted),      32'd0);
        chk("rst_retired",     32'(retired),     32'd0);
        push_exp(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, RW'(1));
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_fetch_req", 32'(imem_req), 32'd1);
        chk("post_rst_busy",      32'(busy),     32'd1);
        chk("post_rst_ir_load",   32'(ir_load),  32'd1);
        run = 1'b0;
        wait_idle("post_rst_idle", 10);
        chk("post_rst_retired", 32'(retired), 32'd1);

        // Single step of ADD 0x0180.
        push_exp(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, RW'(2));
        step = 1'b1;
        @(negedge clock);                       // FETCH
        step = 1'b0;
        chk("step_fetch_req", 32'(imem_req), 32'd1);
        chk("step_fetch_alu", 32'(alu_control), 32'd0);
        @(negedge clock);                       // DECODE
        step = 1'b1;                            // must be ignored
        chk("step_decode_alu", 32'(alu_control), 32'd0);
        @(negedge clock);                       // EXEC
        step = 1'b0;
        chk("step_exec_alu",  32'(alu_control), 32'b0010);
        chk("step_exec_src",  32'(alu_src),     32'd0);
        chk("step_exec_dst",  32'(reg_dst),     32'd1);
        chk("step_exec_pcw",  32'(pc_write),    32'd0);
        @(negedge clock);                       // WB
        chk("step_wb_pcw", 32'(pc_write),  32'd1);
        chk("step_wb_rw",  32'(reg_write), 32'd1);
        @(negedge clock);                       // IDLE
        chk("step_idle_busy",    32'(busy),        32'd0);
        chk("step_idle_alu",     32'(alu_control), 32'd0);
        chk("step_idle_retired", 32'(retired),     32'd2);
        repeat (2) @(negedge clock);
        chk("step_pulse_ignored", 32'(busy), 32'd0);

        // ADDI 0x5105 with three wait states.
        instr = 16'h5105; mem_lat = 3;
        push_exp(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, RW'(3));
        req_cnt = 0; ack_c = -1; pw_c = -1;
        run = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (imem_req) req_cnt++;
            if (ir_load)  ack_c = c;
            if (pc_write) pw_c = c;
            if (c == 0) run = 1'b0;
            if (c == 5) begin
                chk("addi_exec_src", 32'(alu_src), 32'd1);
                chk("addi_exec_dst", 32'(reg_dst), 32'd0);
            end
            if (c == 7) chk("addi_idle_busy", 32'(busy), 32'd0);
        end
        chk("addi_req_cycles", 32'(req_cnt), 32'd4);
        chk("addi_ir_load_at", 32'(ack_c),   32'd3);
        chk("addi_pc_write_at", 32'(pw_c),   32'd6);

        // Back-to-back SUB 0x1040: pc_write every 4 cycles.
        instr = 16'h1040; mem_lat = 0;
        push_exp(4'b0110, 1'b0, 1'b1, 1'b1, 1'b0, RW'(4));
        push_exp(4'b0110, 1'b0, 1'b1, 1'b1, 1'b0, RW'(5));
        pw1 = -1; pw2 = -1;
        run = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (pc_write) begin
                if (pw1 < 0) pw1 = c;
                else         pw2 = c;
            end
            if (c == 4) run = 1'b0;
            if (c == 8) chk("run_idle_busy", 32'(busy), 32'd0);
        end
        chk("run_first_pcw",  32'(pw1), 32'd3);
        chk("run_second_pcw", 32'(pw2), 32'd7);

        // Illegal opcode 0x9000 with run dropped in EXEC.
        instr = 16'h9000;
        push_exp(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, RW'(6));
        run = 1'b1;
        repeat (3) @(negedge clock);            // EXEC
        chk("ill_exec_alu", 32'(alu_control), 32'b0010);
        run = 1'b0;
        @(negedge clock);                       // WB
        chk("ill_wb_illegal", 32'(illegal),   32'd1);
        chk("ill_wb_rw",      32'(reg_write), 32'd0);
        chk("ill_wb_pcw",     32'(pc_write),  32'd1);
        @(negedge clock);
        chk("ill_idle_busy",    32'(busy),    32'd0);
        chk("ill_idle_illegal", 32'(illegal), 32'd0);

        // Retire counter wrap: 249 instructions to all-ones, one more to 0.
        instr = 16'h0180;
        for (int k = 7; k <= 255; k++) push_exp(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, RW'(k));
        push_exp(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, RW'(0));
        run = 1'b1;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 1200 && !hit; i++) begin
                @(negedge clock);
                #1;
                if (pc_write && sb_q.size() == 1) hit = 1'b1;
            end
            if (!hit) begin
                n_checks++;
                n_fail++;
                $display("FAIL wrap_reach: did not reach last-but-one retire, queue=%0d, required 1", sb_q.size());
            end
        end
        @(posedge clock);
        #1;
        run = 1'b0;
        wait_idle("wrap_idle", 20);
        chk("wrap_retired", 32'(retired), 32'd0);
        chk("wrap_halted",  32'(halted),  32'd0);
        chk("wrap_queue",   32'(sb_q.size()), 32'd0);
        push_exp(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, RW'(1));
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        wait_idle("wrap_step_idle", 10);
        chk("wrap_step_retired", 32'(retired), 32'd1);

        // Reset while an ack is pending in FETCH.
        run = 1'b1;
        @(negedge clock);                       // FETCH with ack
        chk("rack_ir_load_pre", 32'(ir_load), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rack_ir_load_in_reset", 32'(ir_load), 32'd0);
        @(negedge clock);
        chk("rack_imem_req", 32'(imem_req), 32'd0);
        chk("rack_busy",     32'(busy),     32'd0);
        chk("rack_retired",  32'(retired),  32'd0);
        reset_n = 1'b1; run = 1'b0;
        repeat (3) @(negedge clock);
        chk("rack_stays_idle", 32'(busy), 32'd0);

        // Halt word: sticky until reset.
        instr = 16'hFFFF;
        run = 1'b1;
        @(negedge clock);                       // FETCH
        @(negedge clock);                       // DECODE
        chk("halt_decode_busy",   32'(busy),   32'd1);
        chk("halt_decode_halted", 32'(halted), 32'd0);
        @(negedge clock);                       // HALT
        chk("halt_halted",  32'(halted),  32'd1);
        chk("halt_busy",    32'(busy),    32'd0);
        chk("halt_retired", 32'(retired), 32'd0);
        for (int c = 0; c < 8; c++) begin
            run  = c[0];
            step = c[1];
            @(negedge clock);
            chk("halt_sticky", 32'(halted), 32'd1);
        end
        chk("halt_retired_after", 32'(retired), 32'd0);
        run = 1'b0; step = 1'b0; reset_n = 1'b0;
        @(negedge clock);
        chk("halt_reset_halted", 32'(halted), 32'd0);
        chk("halt_reset_busy",   32'(busy),   32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("halt_reset_idle", 32'(busy), 32'd0);

        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
